// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor that computes a - b - bin one bit per clock,
//            LSB first. It also reports the borrow-out and the signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int                 c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0]    c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_diff;
  logic [c_CW-1:0]   r_cnt;
  logic              r_br;
  logic              r_amsb;
  logic              r_bmsb;
  logic              r_bout;
  logic              r_ovf;
  logic              w_d;
  logic              w_br_next;
  logic              w_last;

  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last    = (r_cnt == c_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_br   <= bin;
            r_amsb <= a[WIDTH-1];
            r_bmsb <= b[WIDTH-1];
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          // Result bits enter at the MSB, so after WIDTH shifts the word is aligned.
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_bout <= w_br_next;
            r_ovf  <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor. It applies directed and
//            random operands and compares them against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] ed, output logic eb, output logic eo);
    longint r;
    r  = longint'(ma) - longint'(mb) - longint'(mbin);
    ed = W'(r & ((longint'(1) << W) - 1));
    eb = (r < 0);
    eo = (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ ed[W-1]);
  endfunction

  // Entered and left on a falling edge. The caller may chain calls back-to-back.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input bit noise);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    model(ta, tb_v, tbin, ed, eb, eo);
    start = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      check_eq("run_busy", {31'd0, busy}, 32'd1);
      check_eq("run_done", {31'd0, done}, 32'd0);
      if (noise) begin
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        start = (k == 3);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("done_busy",  {31'd0, busy}, 32'd0);
    check_eq("diff", {24'd0, diff}, {24'd0, ed});
    check_eq("bout", {31'd0, bout}, {31'd0, eb});
    check_eq("ovf",  {31'd0, ovf},  {31'd0, eo});
    @(negedge clk);
    check_eq("idle_done", {31'd0, done}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("hold_diff", {24'd0, diff}, {24'd0, ed});
    check_eq("hold_bout", {31'd0, bout}, {31'd0, eb});
    check_eq("hold_ovf",  {31'd0, ovf},  {31'd0, eo});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_diff", {24'd0, diff}, 32'd0);
    check_eq("rst_bout", {31'd0, bout}, 32'd0);
    check_eq("rst_ovf",  {31'd0, ovf},  32'd0);

    // Start is accepted on the very first edge with reset released.
    rst_n = 1'b1;
    do_op(8'h05, 8'h03, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    do_op(8'h10, 8'h0F, 1'b1, 1'b0);
    do_op(8'h00, 8'hFF, 1'b1, 1'b0);
    do_op(8'h3C, 8'h5A, 1'b1, 1'b1);

    // Idle hold with start low.
    repeat (3) @(negedge clk);
    check_eq("idle_hold_done", {31'd0, done}, 32'd0);
    check_eq("idle_hold_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of an operation.
    start = 1'b1; a = 8'hA5; b = 8'h13; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_diff", {24'd0, diff}, 32'd0);
    check_eq("mid_rst_bout", {31'd0, bout}, 32'd0);
    check_eq("mid_rst_ovf",  {31'd0, ovf},  32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      check_eq("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    do_op(8'hA5, 8'h13, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 The block SHALL have port b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 The block SHALL have port bin  input  1  borrow-in; captured on the accepting edge.
REQ-008 The block SHALL have port busy  output  1  high while a subtraction is in progress (RUN).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when the result is valid (DONE).
REQ-010 The block SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout  output  1  borrow-out; 1 iff unsigned a < b + bin.
REQ-012 The block SHALL have port ovf  output  1  two's-complement overflow of the signed subtraction.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL capture a, b and bin, clear the bit counter, and enter RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE with diff, bout and ovf held.
REQ-016 In RUN, each edge SHALL compute one result bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-017 The borrow register SHALL be initialised to the captured bin and updated each RUN cycle.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the WIDTH-th RUN edge the FSM SHALL enter DONE.
REQ-019 Latency: for start accepted at edge 0, done SHALL be high for exactly the cycle following edge WIDTH.
REQ-020 In DONE, diff SHALL hold the full result, bout the final borrow, and ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]).
REQ-021 From DONE, the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-022 diff, bout and ovf SHALL hold their DONE values in IDLE until the next accepted start.
REQ-023 start asserted in RUN or DONE SHALL be ignored, with no effect on state, operands or result; it is not queued.
REQ-024 Operand inputs changing during RUN SHALL have no effect, because only the captured copies are used.
REQ-025 Back-to-back operation: start high in the IDLE cycle directly after DONE SHALL be accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-026 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; both SHALL never be high together.

Reset
REQ-027 An edge with rst_n=0 SHALL force IDLE, with busy=0, done=0, diff=0, bout=0, ovf=0, and clear the counter and borrow register.
REQ-028 Reset SHALL take priority over start and over any in-progress operation; a partial result SHALL be discarded and done SHALL not pulse.
REQ-029 Start may be accepted on the first edge with rst_n=1.

Verification (WIDTH=8)
REQ-030 A bench SHALL apply a=8'h05, b=8'h03, bin=0, start at edge 0 -> busy for edges 1-8, done=1 after edge 8, diff=8'h02, bout=0, ovf=0.
REQ-031 A bench SHALL apply a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1, ovf=0.
REQ-032 A bench SHALL apply a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1; then a=8'h7F, b=8'hFF -> diff=8'h80, bout=1, ovf=1.
REQ-033 A bench SHALL apply a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, bout=0; and a=8'h00, b=8'hFF, bin=1 -> diff=8'h00, bout=1.
REQ-034 A bench SHALL pulse start at RUN cycle 3 with different operands and change a/b mid-RUN -> first result unchanged, done pulses exactly once.
REQ-035 A bench SHALL assert rst_n=0 at RUN cycle 4 -> next cycle busy=0, done=0, diff=0; done SHALL not pulse; a new start after release SHALL complete normally.
